// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer for the stage-3 ALU: PC+4, execute or compare/branch-target, one-cycle done.
// Optional overflow trap is compiled in when ALU_SEQ_OVF_TRAP_EN is defined.
module alu_seq_ctrl #(
    parameter int         CTRL_W   = 22,
    parameter logic [5:0] OP_RTYPE = 6'h00,
    parameter logic [5:0] OP_BEQ   = 6'h04,
    parameter logic [5:0] OP_BNE   = 6'h05,
    parameter logic [5:0] OP_ADDI  = 6'h08,
    parameter logic [5:0] OP_ANDI  = 6'h0C,
    parameter logic [5:0] OP_ORI   = 6'h0D,
    parameter logic [5:0] OP_XORI  = 6'h0E
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [5:0]        op,
    input  logic [5:0]        fn,
    output logic              ready,
    output logic [CTRL_W-1:0] ctrl_out,
    input  logic [31:0]       z_in,
    input  logic              alu_zero,
    input  logic              ovfl,
    output logic [31:0]       z_q,
    output logic [31:0]       result,
    output logic [31:0]       npc,
    output logic              br_taken,
    output logic              wr_en,
    output logic              illegal,
    output logic              exc,
    output logic              done
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PC   = 3'd1;
    localparam logic [2:0] S_EXEC = 3'd2;
    localparam logic [2:0] S_CMP  = 3'd3;
    localparam logic [2:0] S_BR   = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;

    localparam logic [7:0] CTRL_PC4 = 8'h00;
    localparam logic [7:0] CTRL_CMP = 8'h54;
    localparam logic [7:0] CTRL_BR  = 8'hB0;

    function automatic logic [7:0] exec_code(input logic [5:0] op_v, input logic [5:0] fn_v);
        logic [7:0] c;
        c = CTRL_PC4;
        if (op_v == OP_RTYPE) begin
            case (fn_v)
                FN_ADD:  c = 8'h50;
                FN_SUB:  c = 8'h54;
                FN_AND:  c = 8'h51;
                FN_OR:   c = 8'h55;
                FN_XOR:  c = 8'h59;
                FN_NOR:  c = 8'h5D;
                FN_SLL:  c = 8'h6A;
                FN_SRL:  c = 8'h66;
                FN_SRA:  c = 8'h6E;
                default: c = CTRL_PC4;
            endcase
        end else if (op_v == OP_ADDI) begin
            c = 8'h60;
        end else if (op_v == OP_ANDI) begin
            c = 8'h61;
        end else if (op_v == OP_ORI) begin
            c = 8'h65;
        end else if (op_v == OP_XORI) begin
            c = 8'h69;
        end
        return c;
    endfunction

    function automatic logic alu_legal(input logic [5:0] op_v, input logic [5:0] fn_v);
        logic ok;
        ok = 1'b0;
        if (op_v == OP_RTYPE) begin
            case (fn_v)
                FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_NOR,
                FN_SLL, FN_SRL, FN_SRA: ok = 1'b1;
                default:                ok = 1'b0;
            endcase
        end else if (op_v == OP_ADDI || op_v == OP_ANDI || op_v == OP_ORI || op_v == OP_XORI) begin
            ok = 1'b1;
        end
        return ok;
    endfunction

    logic [2:0]  r_state;
    logic [5:0]  r_op;
    logic [5:0]  r_fn;
    logic [31:0] r_z_q;
    logic [31:0] r_result;
    logic [31:0] r_npc;
    logic        r_br_taken;
    logic        r_wr_en;
    logic        r_illegal;
    logic        r_ovf_q;

    logic        w_in_legal;
    logic        w_is_branch;
    logic        w_is_arith;
    logic [7:0]  w_ctrl8;

    assign w_in_legal  = alu_legal(op, fn) || (op == OP_BEQ) || (op == OP_BNE);
    assign w_is_branch = (r_op == OP_BEQ) || (r_op == OP_BNE);
    assign w_is_arith  = (r_op == OP_ADDI) ||
                         ((r_op == OP_RTYPE) && ((r_fn == FN_ADD) || (r_fn == FN_SUB)));

    // Control word is a pure decode of the phase and the latched instruction.
    always_comb begin
        w_ctrl8 = CTRL_PC4;
        case (r_state)
            S_EXEC:  w_ctrl8 = exec_code(r_op, r_fn);
            S_CMP:   w_ctrl8 = CTRL_CMP;
            S_BR:    w_ctrl8 = CTRL_BR;
            default: w_ctrl8 = CTRL_PC4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_op       <= '0;
            r_fn       <= '0;
            r_z_q      <= '0;
            r_result   <= '0;
            r_npc      <= '0;
            r_br_taken <= 1'b0;
            r_wr_en    <= 1'b0;
            r_illegal  <= 1'b0;
            r_ovf_q    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op       <= op;
                        r_fn       <= fn;
                        r_br_taken <= 1'b0;
                        r_wr_en    <= 1'b0;
                        r_ovf_q    <= 1'b0;
                        r_illegal  <= ~w_in_legal;
                        r_state    <= w_in_legal ? S_PC : S_DONE;
                    end
                end
                S_PC: begin
                    r_z_q   <= z_in;
                    r_state <= w_is_branch ? S_CMP : S_EXEC;
                end
                S_EXEC: begin
                    r_result <= z_in;
                    r_wr_en  <= 1'b1;
                    r_ovf_q  <= ovfl & w_is_arith;
                    r_npc    <= r_z_q;
                    r_state  <= S_DONE;
                end
                S_CMP: begin
                    r_br_taken <= (r_op == OP_BEQ) ? alu_zero : ~alu_zero;
                    r_state    <= S_BR;
                end
                // z_q still holds PC+4, so the not-taken path needs no extra ALU pass.
                S_BR: begin
                    r_npc   <= r_br_taken ? z_in : r_z_q;
                    r_state <= S_DONE;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ready    = (r_state == S_IDLE);
    assign done     = (r_state == S_DONE);
    assign ctrl_out = {{(CTRL_W-8){1'b0}}, w_ctrl8};
    assign z_q      = r_z_q;
    assign result   = r_result;
    assign npc      = r_npc;
    assign br_taken = r_br_taken;
    assign illegal  = r_illegal;

`ifdef ALU_SEQ_OVF_TRAP_EN
    assign exc   = r_ovf_q;
    assign wr_en = r_wr_en & ~r_ovf_q;
`else
    logic w_unused_ovf;
    assign w_unused_ovf = r_ovf_q;
    assign exc          = 1'b0;
    assign wr_en        = r_wr_en;
`endif

endmodule
